mpu_cmd_parser: RTL
===================

MPU_CMD_PARSER -- requirements
Module: mpu_cmd_parser

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 16: number of clk cycles mpu_rst_req is held after an 'r' command.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000: idle clk cycles allowed between hex digits of a 'd' command before abort.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port rx_data, input, 8: received byte from avr_interface.
REQ-006 Port new_rx_data, input, 1: one-cycle strobe, rx_data valid.
REQ-007 Port tx_busy, input, 1: transmitter busy; new_tx_data not to be pulsed while high.
REQ-008 Port tx_data, output, 8: response byte.
REQ-009 Port new_tx_data, output, 1: one-cycle strobe, tx_data valid.
REQ-010 Port step_pulse, output, 1: one-cycle single-step request to the MPU clock divider.
REQ-011 Port mpu_rst_req, output, 1: MPU reset request, active-high level.
REQ-012 Port run_en, output, 1: free-run clock enable.
REQ-013 Port data_override, output, 8: byte to drive on the 6502 data bus.
REQ-014 Port override_en, output, 1: data_override valid; otherwise top level drives NOP (0xEA).
REQ-015 Port cmd_error, output, 1: one-cycle pulse on any rejected or aborted command.

Function
REQ-016 The FSM SHALL have states IDLE, HEX_HI, HEX_LO, RST_HOLD, RESPOND.
REQ-017 In IDLE, 's'/'S' SHALL pulse step_pulse the cycle after the new_rx_data strobe, then go to RESPOND with '+' (0x2B).
REQ-018 In IDLE, 'r'/'R' SHALL assert mpu_rst_req the next cycle, hold it exactly RST_HOLD_CYCLES cycles in RST_HOLD, deassert, then go to RESPOND with '+'.
REQ-019 In IDLE, 'g'/'G' SHALL set run_en=1 and 'h'/'H' SHALL clear run_en; each responds '+'.
REQ-020 In IDLE, 'd'/'D' SHALL go to HEX_HI; 'n'/'N' SHALL clear override_en and respond '+'.
REQ-021 In IDLE, CR (0x0D) and LF (0x0A) SHALL be ignored silently; any other byte SHALL pulse cmd_error and respond '?' (0x3F).
REQ-022 HEX_HI/HEX_LO SHALL accept '0'-'9', 'a'-'f', 'A'-'F'; after HEX_LO, data_override SHALL load {hi,lo} and override_en SHALL be set in the same cycle, then respond '+'.
REQ-023 A non-hex byte in HEX_HI/HEX_LO SHALL abort: data_override and override_en unchanged, cmd_error pulsed, respond '?'.
REQ-024 The timeout counter SHALL restart on each byte accepted in HEX_HI/HEX_LO; reaching TIMEOUT_CYCLES SHALL abort as in REQ-023.
REQ-025 In RESPOND, tx_data SHALL be held stable and new_tx_data pulsed for exactly one cycle on the first cycle tx_busy=0, then the FSM returns to IDLE.
REQ-026 new_rx_data received in RST_HOLD or RESPOND SHALL be dropped with no other effect.
REQ-027 step_pulse SHALL never be asserted for more than one consecutive cycle.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE, counters clear, tx_data=0x00, new_tx_data=0, step_pulse=0, mpu_rst_req=0, run_en=0, data_override=0xEA, override_en=0, cmd_error=0.
REQ-029 Reset mid-command, including mid-RST_HOLD, SHALL abort it with no response byte sent.

Structure
REQ-030 Package mpu_cmd_pkg SHALL hold the state enum, ASCII command/response constants and the NOP constant 0xEA.
REQ-031 A combinational sub-module ascii_hex_decode SHALL map an 8-bit ASCII byte to a 4-bit nibble plus a valid flag.

Verification
REQ-032 Sequence 's' with tx_busy=0 -> step_pulse high exactly 1 cycle; tx_data=0x2B with one new_tx_data pulse.
REQ-033 Sequence 'd','3','F' -> data_override=0x3F, override_en=1, response '+'; sequence 'D','g','1' -> cmd_error pulse, '?', data_override still 0x3F.
REQ-034 Send 'r' with RST_HOLD_CYCLES=16 -> mpu_rst_req high exactly 16 cycles; an 's' sent during the hold is dropped (no step_pulse).
REQ-035 Send 'g' with tx_busy held high 100 cycles -> run_en=1 immediately; new_tx_data pulses once, only after tx_busy falls.
REQ-036 Send 'd','A' then idle TIMEOUT_CYCLES (set to 64) -> cmd_error pulse, '?' response, override_en unchanged; 'x' -> '?'; 0x0D -> no response.
REQ-037 Assert rst during HEX_LO and during RST_HOLD -> all outputs at REQ-028 values, no new_tx_data pulse afterwards.

Source files
------------

// File: rtl/mpu_cmd_pkg.sv
// Shared types and ASCII constants for the MPU serial command parser.
package mpu_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEX_HI,
        HEX_LO,
        RST_HOLD,
        RESPOND
    } state_t;

    localparam logic [7:0] CMD_STEP     = 8'h73;
    localparam logic [7:0] CMD_RESET    = 8'h72;
    localparam logic [7:0] CMD_GO       = 8'h67;
    localparam logic [7:0] CMD_HALT     = 8'h68;
    localparam logic [7:0] CMD_DATA     = 8'h64;
    localparam logic [7:0] CMD_NO_DATA  = 8'h6E;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] RESP_OK      = 8'h2B;
    localparam logic [7:0] RESP_ERR     = 8'h3F;
    localparam logic [7:0] NOP_OPCODE   = 8'hEA;

    // Commands are case-insensitive, so fold A-Z onto a-z before matching.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Maps an ASCII hex digit (0-9, a-f, A-F) to its nibble value.
module ascii_hex_decode (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        unique case (1'b1)
            (ascii >= 8'h30 && ascii <= 8'h39): begin
                nibble = ascii[3:0];
                valid  = 1'b1;
            end
            (ascii >= 8'h61 && ascii <= 8'h66),
            (ascii >= 8'h41 && ascii <= 8'h46): begin
                nibble = ascii[3:0] + 4'd9;
                valid  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mpu_cmd_parser.sv
// Single-character command parser driving MPU step/run/reset and
// data-bus override, answering each command with '+' or '?'.
module mpu_cmd_parser
    import mpu_cmd_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       step_pulse,
    output logic       mpu_rst_req,
    output logic       run_en,
    output logic [7:0] data_override,
    output logic       override_en,
    output logic       cmd_error
);

    localparam int RW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    hi_nib;
    logic [3:0]    nib;
    logic          nib_valid;

    ascii_hex_decode u_hex (
        .ascii  (rx_data),
        .nibble (nib),
        .valid  (nib_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rst_cnt       <= '0;
            to_cnt        <= '0;
            hi_nib        <= 4'h0;
            tx_data       <= 8'h00;
            new_tx_data   <= 1'b0;
            step_pulse    <= 1'b0;
            mpu_rst_req   <= 1'b0;
            run_en        <= 1'b0;
            data_override <= NOP_OPCODE;
            override_en   <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            step_pulse  <= 1'b0;
            new_tx_data <= 1'b0;
            cmd_error   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (new_rx_data) begin
                        tx_data <= RESP_OK;
                        state   <= RESPOND;
                        unique case (to_lower(rx_data))
                            CMD_STEP:    step_pulse <= 1'b1;
                            CMD_GO:      run_en <= 1'b1;
                            CMD_HALT:    run_en <= 1'b0;
                            CMD_NO_DATA: override_en <= 1'b0;
                            CMD_RESET: begin
                                mpu_rst_req <= 1'b1;
                                rst_cnt     <= '0;
                                state       <= RST_HOLD;
                            end
                            CMD_DATA: begin
                                to_cnt <= '0;
                                state  <= HEX_HI;
                            end
                            ASCII_CR, ASCII_LF: state <= IDLE;
                            default: begin
                                cmd_error <= 1'b1;
                                tx_data   <= RESP_ERR;
                            end
                        endcase
                    end
                end
                HEX_HI, HEX_LO: begin
                    if (new_rx_data && nib_valid) begin
                        to_cnt <= '0;
                        if (state == HEX_HI) begin
                            hi_nib <= nib;
                            state  <= HEX_LO;
                        end else begin
                            data_override <= {hi_nib, nib};
                            override_en   <= 1'b1;
                            tx_data       <= RESP_OK;
                            state         <= RESPOND;
                        end
                    end else if (new_rx_data ||
                                 to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        cmd_error <= 1'b1;
                        tx_data   <= RESP_ERR;
                        state     <= RESPOND;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RST_HOLD: begin
                    if (rst_cnt == RW'(RST_HOLD_CYCLES - 1)) begin
                        mpu_rst_req <= 1'b0;
                        tx_data     <= RESP_OK;
                        state       <= RESPOND;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    if (!tx_busy) begin
                        new_tx_data <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
